// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the parametrised USB full-speed receiver.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SYNC, ST_PID, ST_DATA, ST_EOP, ST_ERR
    } rx_state_e;

    localparam logic [3:0] PID_OUT   = 4'h1;
    localparam logic [3:0] PID_IN    = 4'h9;
    localparam logic [3:0] PID_SOF   = 4'h5;
    localparam logic [3:0] PID_SETUP = 4'hD;
    localparam logic [3:0] PID_DATA0 = 4'h3;
    localparam logic [3:0] PID_DATA1 = 4'hB;
    localparam logic [3:0] PID_ACK   = 4'h2;
    localparam logic [3:0] PID_NAK   = 4'hA;
    localparam logic [3:0] PID_STALL = 4'hE;

    localparam logic [7:0]  SYNC_BYTE      = 8'h80;
    localparam logic [15:0] CRC16_POLY     = 16'h8005;
    localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

    // Upper nibble carries the one's complement of the PID as a check field.
    function automatic logic pid_ok(input logic [7:0] b);
        return b[7:4] == ~b[3:0];
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_rx_fifo.sv
// First-word-fall-through byte FIFO; head byte reads as 0 while empty.
module usb_rx_fifo #(
    parameter  int DEPTH = 64,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             wr_en_i,
    input  logic [7:0]       wr_data_i,
    input  logic             rd_en_i,
    output logic [7:0]       rd_data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o
);

    logic [7:0]       mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q;
    logic             do_rd, do_wr;

    assign empty_o   = (cnt_q == '0);
    assign full_o    = (cnt_q == CNT_W'(DEPTH));
    assign do_rd     = rd_en_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts it.
    assign do_wr     = wr_en_i && (!full_o || do_rd);
    assign ovf_o     = wr_en_i && !do_wr;
    assign rd_data_o = empty_o ? 8'h00 : mem_q[rptr_q];
    assign count_o   = cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + AW'(1);
            if (do_rd) rptr_q <= rptr_q + AW'(1);
            case ({do_wr, do_rd})
                2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/usb_rx_param.sv
// USB full-speed receiver: oversampled bit recovery, NRZI/destuff, packet FSM, FWFT FIFO.
// Define USB_RX_CRC16_EN to add DATA0/DATA1 CRC16 residual checking at EOP.
module usb_rx_param
    import usb_rx_pkg::*;
#(
    parameter  int CLKS_PER_BIT = 8,
    parameter  int FIFO_DEPTH   = 64,
    localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_plus,
    input  logic             d_minus,
    input  logic             r_enable,
    output logic [7:0]       r_data,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic             rcving,
    output logic             r_error,
    output logic [3:0]       PID,
    output logic             pkt_done
);

    localparam int TW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic            dp_m_q, dp_s_q, dp_p_q, dm_m_q, dm_s_q;
    logic [TW-1:0]   tmr_q;
    rx_state_e       st_q;
    logic            prev_q, se0_seen_q, rcving_q, rerr_q, done_q;
    logic [2:0]      ones_q, bcnt_q;
    logic [6:0]      sh_q;
    logic [3:0]      pid_q;
`ifdef USB_RX_CRC16_EN
    logic [15:0]     crc_q;
    logic            crc_on_q;
`endif

    logic       edge_w, fall_w, smp, se0, nbit, in_rx, stuff, bit_ok, byte_done, j_smp, bad, ovf;
    logic [7:0] byte_w;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_m_q <= 1'b1;
            dp_s_q <= 1'b1;
            dp_p_q <= 1'b1;
            dm_m_q <= 1'b0;
            dm_s_q <= 1'b0;
            tmr_q  <= '0;
        end else begin
            dp_m_q <= d_plus;
            dp_s_q <= dp_m_q;
            dp_p_q <= dp_s_q;
            dm_m_q <= d_minus;
            dm_s_q <= dm_m_q;
            if (edge_w || tmr_q == TW'(CLKS_PER_BIT - 1)) tmr_q <= '0;
            else                                          tmr_q <= tmr_q + TW'(1);
        end
    end

    assign edge_w    = dp_s_q ^ dp_p_q;
    assign fall_w    = dp_p_q && !dp_s_q;
    assign smp       = !edge_w && (tmr_q == TW'(HALF - 1));
    assign se0       = !dp_s_q && !dm_s_q;
    assign nbit      = (dp_s_q == prev_q);
    assign in_rx     = (st_q == ST_SYNC) || (st_q == ST_PID) || (st_q == ST_DATA);
    assign stuff     = (ones_q == 3'd6);
    assign bit_ok    = smp && in_rx && !se0 && !stuff;
    assign byte_w    = {nbit, sh_q};
    assign byte_done = bit_ok && (bcnt_q == 3'd7);
    assign j_smp     = smp && dp_s_q;

    // Every condition that aborts a packet, evaluated at the sample point.
    always_comb begin
        bad = 1'b0;
        if (smp && in_rx) begin
            if (se0)             bad = (st_q != ST_DATA) || (bcnt_q != 3'd0);
            else if (stuff)      bad = nbit;
            else if (bcnt_q == 3'd7) begin
                if (st_q == ST_SYNC)     bad = (byte_w != SYNC_BYTE);
                else if (st_q == ST_PID) bad = !pid_ok(byte_w);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            st_q       <= ST_IDLE;
            prev_q     <= 1'b1;
            ones_q     <= '0;
            bcnt_q     <= '0;
            sh_q       <= '0;
            se0_seen_q <= 1'b0;
            rcving_q   <= 1'b0;
            rerr_q     <= 1'b0;
            pid_q      <= 4'hF;
            done_q     <= 1'b0;
`ifdef USB_RX_CRC16_EN
            crc_q      <= 16'hFFFF;
            crc_on_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (smp) prev_q <= dp_s_q;
            if (bit_ok) begin
                ones_q <= nbit ? ones_q + 3'd1 : 3'd0;
                sh_q   <= byte_w[7:1];
                bcnt_q <= bcnt_q + 3'd1;
            end else if (smp && in_rx && !se0 && stuff) begin
                ones_q <= 3'd0;
            end
            if (ovf) rerr_q <= 1'b1;
            if (bad) begin
                st_q       <= ST_ERR;
                rerr_q     <= 1'b1;
                se0_seen_q <= se0;
            end else begin
                case (st_q)
                    ST_IDLE: if (fall_w) begin
                        st_q     <= ST_SYNC;
                        rcving_q <= 1'b1;
                        ones_q   <= '0;
                        bcnt_q   <= '0;
                    end
                    ST_SYNC: if (byte_done) begin
                        rerr_q <= 1'b0;
                        st_q   <= ST_PID;
                    end
                    ST_PID: if (byte_done) begin
                        pid_q <= byte_w[3:0];
                        st_q  <= ST_DATA;
`ifdef USB_RX_CRC16_EN
                        crc_q    <= 16'hFFFF;
                        crc_on_q <= (byte_w[3:0] == PID_DATA0) || (byte_w[3:0] == PID_DATA1);
`endif
                    end
                    ST_DATA: begin
                        if (smp && se0) st_q <= ST_EOP;
`ifdef USB_RX_CRC16_EN
                        if (bit_ok) crc_q <= crc16_step(crc_q, nbit);
`endif
                    end
                    ST_EOP: if (j_smp) begin
                        rcving_q <= 1'b0;
                        st_q     <= ST_IDLE;
`ifdef USB_RX_CRC16_EN
                        if (crc_on_q && crc_q != CRC16_RESIDUAL) rerr_q <= 1'b1;
                        else                                      done_q <= 1'b1;
`else
                        done_q <= 1'b1;
`endif
                    end
                    ST_ERR: begin
                        if (smp && se0) begin
                            se0_seen_q <= 1'b1;
                        end else if (j_smp && se0_seen_q) begin
                            se0_seen_q <= 1'b0;
                            rcving_q   <= 1'b0;
                            st_q       <= ST_IDLE;
                        end
                    end
                    default: st_q <= ST_IDLE;
                endcase
            end
        end
    end

    usb_rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .n_rst     (n_rst),
        .wr_en_i   (byte_done && st_q == ST_DATA),
        .wr_data_i (byte_w),
        .rd_en_i   (r_enable),
        .rd_data_o (r_data),
        .empty_o   (empty),
        .full_o    (full),
        .count_o   (count),
        .ovf_o     (ovf)
    );

    assign rcving   = rcving_q;
    assign r_error  = rerr_q;
    assign PID      = pid_q;
    assign pkt_done = done_q;

endmodule

// File: tb/tb_usb_rx_param.sv
// Directed bench: three receivers (default, 4-deep FIFO, 12x oversample with jitter).
module tb_usb_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       n_rst;
    logic       dp [3];
    logic       dm [3];
    logic       ren [3];
    logic [7:0] rd0, rd1, rd2;
    logic       em0, em1, em2, fu0, fu1, fu2, rcv0, rcv1, rcv2;
    logic       err0, err1, err2, done0, done1, done2;
    logic [6:0] cnt0, cnt2;
    logic [2:0] cnt1;
    logic [3:0] pid0, pid1, pid2;
    int         checks = 0;
    int         errors = 0;
    int         pd [3];
    int         rv [3];

    usb_rx_param #(.CLKS_PER_BIT(8), .FIFO_DEPTH(64)) dut0 (
        .clk(clk), .n_rst(n_rst), .d_plus(dp[0]), .d_minus(dm[0]), .r_enable(ren[0]),
        .r_data(rd0), .empty(em0), .full(fu0), .count(cnt0), .rcving(rcv0),
        .r_error(err0), .PID(pid0), .pkt_done(done0));
    usb_rx_param #(.CLKS_PER_BIT(8), .FIFO_DEPTH(4)) dut1 (
        .clk(clk), .n_rst(n_rst), .d_plus(dp[1]), .d_minus(dm[1]), .r_enable(ren[1]),
        .r_data(rd1), .empty(em1), .full(fu1), .count(cnt1), .rcving(rcv1),
        .r_error(err1), .PID(pid1), .pkt_done(done1));
    usb_rx_param #(.CLKS_PER_BIT(12), .FIFO_DEPTH(64)) dut2 (
        .clk(clk), .n_rst(n_rst), .d_plus(dp[2]), .d_minus(dm[2]), .r_enable(ren[2]),
        .r_data(rd2), .empty(em2), .full(fu2), .count(cnt2), .rcving(rcv2),
        .r_error(err2), .PID(pid2), .pkt_done(done2));

    always @(negedge clk) begin
        if (done0 === 1'b1) pd[0]++;
        if (done1 === 1'b1) pd[1]++;
        if (done2 === 1'b1) pd[2]++;
        if (rcv0 === 1'b1) rv[0]++;
    end

    task automatic drive_lvl(input int k, input logic p, input logic m, input int n);
        dp[k] = p;
        dm[k] = m;
        repeat (n) @(negedge clk);
    endtask

    task automatic pop(input int k);
        ren[k] = 1'b1;
        @(negedge clk);
        ren[k] = 1'b0;
    endtask

    // SYNC + PID + n data bytes, LSB first, stuffed and NRZI coded, then SE0 x2 and idle J.
    task automatic send_pkt(input int k, input int cpb, input logic [7:0] pid, input logic [7:0] d [8],
                            input int n, input bit bad_stuff, input int stop_at, input bit jit);
        bit         q[$];
        logic [7:0] by;
        int         ones;
        bit         stuffed;
        logic       lvl;
        ones = 0;
        stuffed = 0;
        for (int i = 0; i < n + 2; i++) begin
            if (i == 0)      by = 8'h80;
            else if (i == 1) by = pid;
            else             by = d[i-2];
            for (int j = 0; j < 8; j++) begin
                q.push_back(by[j]);
                ones = by[j] ? ones + 1 : 0;
                if (ones == 6) begin
                    q.push_back(bad_stuff && !stuffed);
                    stuffed = 1;
                    ones = 0;
                end
            end
        end
        lvl = 1'b1;
        foreach (q[i]) begin
            if (stop_at > 0 && i >= stop_at) return;
            if (!q[i]) lvl = ~lvl;
            drive_lvl(k, lvl, ~lvl, cpb + (jit ? (i % 3) - 1 : 0));
        end
        drive_lvl(k, 1'b0, 1'b0, 2 * cpb);
        drive_lvl(k, 1'b1, 1'b0, 5 * cpb);
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h exp 00", rd0); end
        checks++; if (em0 !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b exp 1", em0); end
        checks++; if (fu0 !== 1'b0) begin errors++; $display("FAIL reset_full: got %b exp 0", fu0); end
        checks++; if (cnt0 !== 7'd0) begin errors++; $display("FAIL reset_count: got %0d exp 0", cnt0); end
        checks++; if (rcv0 !== 1'b0) begin errors++; $display("FAIL reset_rcving: got %b exp 0", rcv0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_rerror: got %b exp 0", err0); end
        checks++; if (pid0 !== 4'hF) begin errors++; $display("FAIL reset_pid: got %h exp F", pid0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_pktdone: got %b exp 0", done0); end
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] d [8];
        int p0, r0;
        d = '{8'hA5, 8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        p0 = pd[0];
        r0 = rv[0];
        send_pkt(0, 8, 8'hC3, d, 2, 0, 0, 0);
        checks++; if (pid0 !== 4'h3) begin errors++; $display("FAIL basic_pid: got %h exp 3", pid0); end
        checks++; if (cnt0 !== 7'd2) begin errors++; $display("FAIL basic_count: got %0d exp 2", cnt0); end
        checks++; if (pd[0] - p0 != 1) begin errors++; $display("FAIL basic_pktdone: got %0d pulses exp 1", pd[0] - p0); end
        checks++; if (!(rv[0] > r0)) begin errors++; $display("FAIL basic_rcving_seen: got %0d cycles exp >0", rv[0] - r0); end
        checks++; if (rcv0 !== 1'b0) begin errors++; $display("FAIL basic_rcving_end: got %b exp 0", rcv0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL basic_rerror: got %b exp 0", err0); end
        checks++; if (rd0 !== 8'hA5) begin errors++; $display("FAIL basic_head0: got %h exp A5", rd0); end
        pop(0);
        checks++; if (rd0 !== 8'h3C) begin errors++; $display("FAIL basic_head1: got %h exp 3C", rd0); end
        pop(0);
        checks++; if (em0 !== 1'b1) begin errors++; $display("FAIL basic_empty: got %b exp 1", em0); end
    endtask

    task automatic test_stuff();
        logic [7:0] d [8];
        int p0;
        d = '{8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        p0 = pd[0];
        send_pkt(0, 8, 8'hC3, d, 1, 0, 0, 0);
        checks++; if (pd[0] - p0 != 1) begin errors++; $display("FAIL stuff_pktdone: got %0d exp 1", pd[0] - p0); end
        checks++; if (cnt0 !== 7'd1) begin errors++; $display("FAIL stuff_count: got %0d exp 1", cnt0); end
        checks++; if (rd0 !== 8'hFF) begin errors++; $display("FAIL stuff_data: got %h exp FF", rd0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL stuff_rerror_ok: got %b exp 0", err0); end
        pop(0);
        p0 = pd[0];
        send_pkt(0, 8, 8'h4B, d, 1, 1, 0, 0);
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL stuff_rerror_bad: got %b exp 1", err0); end
        checks++; if (pd[0] - p0 != 0) begin errors++; $display("FAIL stuff_no_pktdone: got %0d exp 0", pd[0] - p0); end
        checks++; if (em0 !== 1'b1) begin errors++; $display("FAIL stuff_no_write: got %b exp 1", em0); end
        checks++; if (rcv0 !== 1'b0) begin errors++; $display("FAIL stuff_rcving: got %b exp 0", rcv0); end
        checks++; if (pid0 !== 4'hB) begin errors++; $display("FAIL stuff_pid: got %h exp B", pid0); end
    endtask

    task automatic test_bad_pid();
        logic [7:0] d [8];
        int p0;
        d = '{8'h11, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        p0 = pd[0];
        send_pkt(0, 8, 8'h33, d, 2, 0, 0, 0);
        checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL badpid_rerror: got %b exp 1", err0); end
        checks++; if (pid0 !== 4'hB) begin errors++; $display("FAIL badpid_pid_kept: got %h exp B", pid0); end
        checks++; if (pd[0] - p0 != 0) begin errors++; $display("FAIL badpid_no_pktdone: got %0d exp 0", pd[0] - p0); end
        checks++; if (cnt0 !== 7'd0) begin errors++; $display("FAIL badpid_count: got %0d exp 0", cnt0); end
        pop(0);
        checks++; if (cnt0 !== 7'd0) begin errors++; $display("FAIL empty_pop_count: got %0d exp 0", cnt0); end
        checks++; if (em0 !== 1'b1) begin errors++; $display("FAIL empty_pop_empty: got %b exp 1", em0); end
        p0 = pd[0];
        send_pkt(0, 8, 8'hD2, d, 0, 0, 0, 0);
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL goodpid_rerror_clr: got %b exp 0", err0); end
        checks++; if (pid0 !== 4'h2) begin errors++; $display("FAIL goodpid_pid: got %h exp 2", pid0); end
        checks++; if (pd[0] - p0 != 1) begin errors++; $display("FAIL goodpid_pktdone: got %0d exp 1", pd[0] - p0); end
    endtask

    task automatic test_overflow();
        logic [7:0] d [8];
        d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h00, 8'h00, 8'h00};
        send_pkt(1, 8, 8'hC3, d, 5, 0, 0, 0);
        checks++; if (fu1 !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b exp 1", fu1); end
        checks++; if (cnt1 !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d exp 4", cnt1); end
        checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL ovf_rerror: got %b exp 1", err1); end
        for (int i = 1; i <= 4; i++) begin
            checks++; if (rd1 !== 8'(i)) begin errors++; $display("FAIL ovf_pop%0d: got %h exp %h", i, rd1, 8'(i)); end
            pop(1);
        end
        checks++; if (em1 !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b exp 1", em1); end
    endtask

    task automatic test_jitter();
        logic [7:0] d [8];
        logic [7:0] exp_b [3];
        int p0;
        d = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        exp_b = '{8'hA5, 8'h3C, 8'hFF};
        p0 = pd[2];
        send_pkt(2, 12, 8'h4B, d, 3, 0, 0, 1);
        checks++; if (pd[2] - p0 != 1) begin errors++; $display("FAIL jit_pktdone: got %0d exp 1", pd[2] - p0); end
        checks++; if (pid2 !== 4'hB) begin errors++; $display("FAIL jit_pid: got %h exp B", pid2); end
        checks++; if (err2 !== 1'b0) begin errors++; $display("FAIL jit_rerror: got %b exp 0", err2); end
        checks++; if (cnt2 !== 7'd3) begin errors++; $display("FAIL jit_count: got %0d exp 3", cnt2); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd2 !== exp_b[i]) begin errors++; $display("FAIL jit_pop%0d: got %h exp %h", i, rd2, exp_b[i]); end
            pop(2);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d [8];
        int p0;
        d = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        send_pkt(0, 8, 8'hC3, d, 3, 0, 28, 0);
        checks++; if (cnt0 !== 7'd1) begin errors++; $display("FAIL mid_count_pre: got %0d exp 1", cnt0); end
        checks++; if (rcv0 !== 1'b1) begin errors++; $display("FAIL mid_rcving_pre: got %b exp 1", rcv0); end
        dp[0] = 1'b1;
        dm[0] = 1'b0;
        #2 n_rst = 1'b0;
        #1;
        checks++; if (rd0 !== 8'h00) begin errors++; $display("FAIL mid_rdata: got %h exp 00", rd0); end
        checks++; if (em0 !== 1'b1) begin errors++; $display("FAIL mid_empty: got %b exp 1", em0); end
        checks++; if (fu0 !== 1'b0) begin errors++; $display("FAIL mid_full: got %b exp 0", fu0); end
        checks++; if (cnt0 !== 7'd0) begin errors++; $display("FAIL mid_count: got %0d exp 0", cnt0); end
        checks++; if (rcv0 !== 1'b0) begin errors++; $display("FAIL mid_rcving: got %b exp 0", rcv0); end
        checks++; if (pid0 !== 4'hF) begin errors++; $display("FAIL mid_pid: got %h exp F", pid0); end
        checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL mid_pktdone: got %b exp 0", done0); end
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        d = '{8'h3C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        p0 = pd[0];
        send_pkt(0, 8, 8'hC3, d, 1, 0, 0, 0);
        checks++; if (pd[0] - p0 != 1) begin errors++; $display("FAIL post_pktdone: got %0d exp 1", pd[0] - p0); end
        checks++; if (cnt0 !== 7'd1) begin errors++; $display("FAIL post_count: got %0d exp 1", cnt0); end
        checks++; if (rd0 !== 8'h3C) begin errors++; $display("FAIL post_data: got %h exp 3C", rd0); end
        checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL post_rerror: got %b exp 0", err0); end
        checks++; if (pid0 !== 4'h3) begin errors++; $display("FAIL post_pid: got %h exp 3", pid0); end
    endtask

    initial begin
        n_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dp[i] = 1'b1;
            dm[i] = 1'b0;
            ren[i] = 1'b0;
        end
        test_reset();
        test_basic();
        test_stuff();
        test_bad_pid();
        test_overflow();
        test_jitter();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/usb_rx_param.md
Name: usb_rx_param

Overview:
Parametrised successor to the fixed full-speed USB receiver. It takes raw d_plus/d_minus, recovers bit timing with a configurable oversample ratio, and performs NRZI decode, bit destuffing, SYNC detect, PID validation and EOP detection. Data bytes are pushed into an internal first-word-fall-through FIFO of configurable depth. It sits between the USB pad synchronisers and the downstream AHB/endpoint logic.

Parameters:
CLKS_PER_BIT, 8, clk cycles per USB bit time; must be ≥4 and even.
FIFO_DEPTH, 64, data FIFO entries (8-bit each); power of two, ≥2.
CNT_W, $clog2(FIFO_DEPTH+1), width of the occupancy count output (derived, not overridden).

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
d_plus  in  1  USB D+ (asynchronous to clk)
d_minus  in  1  USB D- (asynchronous to clk)
r_enable  in  1  pop FIFO head this cycle
r_data  out  8  FIFO head byte (FWFT, valid when !empty)
empty  out  1  FIFO empty
full  out  1  FIFO full
count  out  CNT_W  FIFO occupancy
rcving  out  1  packet reception in progress
r_error  out  1  sticky packet error flag
PID  out  4  last valid PID
pkt_done  out  1  one-cycle pulse on clean EOP

Behaviour:
- Reset values: r_data=0, empty=1, full=0, count=0, rcving=0, r_error=0, PID=4'hF, pkt_done=0. FSM goes to IDLE, FIFO is flushed, bit timer is cleared.
- Input sync: 2-flop synchroniser on each line. Any d_plus transition reloads the bit timer to 0. A sample is taken when the timer reaches CLKS_PER_BIT/2-1; after that the timer counts modulo CLKS_PER_BIT.
- Decode: SE0 = both lines low at a sample. Otherwise the NRZI bit is 1 if d_plus is unchanged since the previous sample, else 0. Idle (J) is d_plus=1.
- Destuff: a counter tracks consecutive decoded 1s. After 6 ones the next bit is discarded. If that discarded bit is 1, raise a stuff error.
- Bytes are assembled LSB first; a byte is complete after 8 destuffed bits.
- FSM states: IDLE, SYNC, PID, DATA, EOP, ERR.
  - IDLE→SYNC on the first d_plus falling edge; rcving=1 from the next cycle.
  - SYNC: the first byte must equal 8'h80, else →ERR.
  - PID: the byte must satisfy upper nibble == ~lower nibble. On success PID<=lower nibble →DATA. On failure →ERR; PID is unchanged.
  - DATA: each complete byte is written to the FIFO. SE0 on a byte boundary →EOP. SE0 mid-byte →ERR.
  - EOP: wait for a J sample. Then pkt_done pulses for 1 cycle, rcving=0, →IDLE.
  - ERR: r_error=1; ignore bits until SE0 followed by J, then rcving=0 →IDLE. No pkt_done is issued.
- r_error clears when the next packet's SYNC validates. Any error in that packet sets it again.
- FIFO: one write per completed byte. A write while full drops the byte and sets r_error; reception continues.
- r_enable while empty is ignored. A simultaneous write and read when full is allowed, and count is unchanged.
- Pointers wrap modulo FIFO_DEPTH. The FIFO is not flushed between packets.
- Write-to-visible latency: the byte appears on r_data with empty=0 one cycle after its last bit sample.
- Asynchronous reset mid-packet returns the block to the reset values immediately. The next packet is received normally.

Optional Feature:
USB_RX_CRC16_EN.
- Defined: a CRC16 (polynomial x^16+x^15+x^2+1, initial value 16'hFFFF, computed per bit on destuffed bits) runs over all DATA-state bits of DATA0/DATA1 PIDs (4'h3/4'hB). At EOP the residual must equal 16'h800D, else r_error=1 and pkt_done is suppressed. CRC bytes are still written to the FIFO.
- Undefined: no CRC logic; the block is bit-identical to the base behaviour.

Decomposition:
- Package usb_rx_pkg: FSM state enum, PID constants (OUT, IN, SOF, SETUP, DATA0, DATA1, ACK, NAK, STALL), SYNC_BYTE=8'h80, CRC16_POLY, CRC16_RESIDUAL=16'h800D.
- One sub-module, usb_rx_fifo: FWFT FIFO parametrised by FIFO_DEPTH with count/full/empty.
- Timing, decode and FSM stay in the top module.

Test Plan:
- Reset, then check all outputs → PID=4'hF, empty=1, r_error=0, rcving=0.
- SYNC, PID DATA0 (8'hC3), bytes 8'hA5, 8'h3C, EOP → PID=4'h3, count=2, pkt_done pulses once, then pops return 8'hA5 then 8'h3C, r_error=0.
- Byte 8'hFF payload (forces a stuff bit after 6 ones) → FIFO gets 8'hFF. A second packet with the stuff bit forced to 1 → r_error=1, no pkt_done.
- Bad PID byte 8'h33 → r_error=1, PID retains its prior value. The next good packet clears r_error.
- FIFO_DEPTH=4 with 5 payload bytes and no reads → full=1, count=4, 5th byte dropped, r_error=1.
- CLKS_PER_BIT=12 with ±1 clk jitter per edge → identical data recovery. Assert n_rst mid-DATA → outputs return to reset values and the next packet is received clean.
